hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard unit for the five-stage core; the counterpart of the decode-side controller. It consumes the controller's stage-qualified control bits (RegWriteM/W, MemtoRegE, PCSrcW, PCWrPendingF, BranchTakenE) and register addresses from the datapath. It returns forwarding selects, stage stalls and flushes, including the FlushE the controller takes as input. It also sequences multi-cycle ALU operations (MUL/DIV class) held in Execute, and keeps saturating stall/flush performance counters.

## Interface
- LONG_LATENCY, 4: total cycles a long op occupies Execute (min 2, max 2^CNT_W)
- CNT_W, 3: width of the long-op down-counter
- PERF_W, 32: width of each performance counter
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- RA1D, RA2D  in  4 each  source register addresses in Decode
- RA1E, RA2E  in  4 each  source register addresses in Execute
- WA3E, WA3M, WA3W  in  4 each  destination addresses in E/M/W
- RegWriteM, RegWriteW  in  1  gated write enables from the controller
- MemtoRegE  in  1  load in Execute
- PCSrcW  in  1  PC write retiring in Writeback
- PCWrPendingF  in  1  PC write in D, E or M
- BranchTakenE  in  1  branch resolved taken in Execute
- LongOpE  in  1  multi-cycle ALU op in Execute
- PerfClear  in  1  synchronous clear of both perf counters
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE  out  1  hold PC, IF/ID, ID/EX registers
- FlushD, FlushE, FlushM  out  1  insert a bubble into D, E, M
- LongDoneE  out  1  one-cycle pulse, long-op result valid this cycle
- StallCount, FlushCount  out  PERF_W each  saturating event counters

## Operation
- Forwarding (combinational). For ForwardAE:
  - 10 if RegWriteM & WA3M==RA1E.
  - else 01 if RegWriteW & WA3W==RA1E.
  - else 00.
  - Never forward when RA1E==15.
  - ForwardBE uses the same rules with RA2E.
- Load-use: LdStall = MemtoRegE & (WA3E==RA1D | WA3E==RA2D).
- Branch and PC-write control:
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - FlushE = (LdStall | BranchTakenE) & ~LongStall.
- Long-op FSM, states IDLE and BUSY, with down-counter cnt:
  - IDLE & LongOpE: LongStall=1; load cnt=LONG_LATENCY-2; next state BUSY.
  - BUSY & cnt!=0: LongStall=1; cnt decrements.
  - BUSY & cnt==0: LongStall=0; LongDoneE=1; next state IDLE.
  - LongOpE is ignored while in BUSY.
- Stall outputs:
  - StallE = LongStall.
  - StallD = LdStall | LongStall.
  - StallF = LdStall | LongStall | PCWrPendingF.
- FlushM = LongStall, so M receives bubbles while E is held.
- LdStall and LongStall may coincide. Stalls win: FlushE stays low, D and E hold.
- Perf counters:
  - StallCount increments on every cycle with StallD=1.
  - FlushCount increments on every cycle with FlushE=1.
  - Both saturate at all-ones.
  - PerfClear has priority over increment.

## Timing
- Reset values:
  - State IDLE, cnt 0, StallCount and FlushCount 0.
  - LongDoneE 0.
  - All other outputs follow their combinational equations.
- Reset asserted mid long op: the FSM aborts to IDLE immediately. There is no LongDoneE for the aborted op.
- Forward, stall and flush outputs have 0-cycle latency: they are valid in the same cycle as their inputs.
- A long op entering E at cycle t holds E for cycles t..t+LONG_LATENCY-1. LongDoneE fires at t+LONG_LATENCY-1, and E advances at the following edge.
- Back-to-back long ops: the second is detected in the first IDLE cycle after release. There is no gap cycle.
- LONG_LATENCY=2: one stall cycle (t), then release at t+1.

## Structure
- Shared package pipeline_pkg holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - The long-op state enum (IDLE, BUSY).
  - REG_PC=4'd15.
- Sub-module hazard_longop_seq holds the FSM and down-counter.
  - Inputs: clk, reset, LongOpE.
  - Outputs: LongStall, LongDoneE.
- Forwarding, load-use, flush logic and perf counters live in the top level.

## Test plan
- RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Repeat with RA1E=15 -> ForwardAE=00.
- MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for exactly one cycle; StallCount +1 and FlushCount +1.
- LONG_LATENCY=4, LongOpE pulse-held from t -> StallE=StallD=StallF=FlushM=1 at t..t+2, LongDoneE=1 only at t+3, FlushE=0 throughout.
- LongOpE with MemtoRegE=1, WA3E=RA1D simultaneously -> FlushE=0 during the hold; load-use stall is re-evaluated after release.
- BranchTakenE=1 -> FlushD=FlushE=1 same cycle. PCWrPendingF=1 -> StallF=FlushD=1, StallD=0.
- Reset driven low at t+1 of a long op -> IDLE, no LongDoneE, counters 0. Preload StallCount to all-ones -> it holds at all-ones. PerfClear with simultaneous increment -> 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: forwarding selects, long-op FSM states and the
// operand-select helper used by the hazard unit.
package pipeline_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } longop_state_e;

    // Memory stage wins over Writeback because it holds the newer value;
    // the PC register is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       rw_m,
        input logic [3:0] wa_m,
        input logic       rw_w,
        input logic [3:0] wa_w,
        input logic [3:0] ra
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ra != REG_PC) begin
            if (rw_m && (wa_m == ra))
                sel = FWD_M;
            else if (rw_w && (wa_w == ra))
                sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_longop_seq.sv
// Sequencer for multi-cycle ALU ops held in Execute: stalls E for
// LONG_LATENCY-1 cycles and pulses LongDoneE in the final cycle.
module hazard_longop_seq
    import pipeline_pkg::*;
#(
    parameter int LONG_LATENCY = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic LongOpE,
    output logic LongStall,
    output logic LongDoneE
);

    longop_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (LongOpE) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LONG_LATENCY - 2);
                end
            end
            BUSY: begin
                // LongOpE is deliberately not sampled here; the op in E owns the unit.
                if (cnt_q != '0)
                    cnt_d = cnt_q - CNT_W'(1);
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        LongStall = 1'b0;
        LongDoneE = 1'b0;
        case (state_q)
            IDLE: LongStall = LongOpE;
            BUSY: begin
                LongStall = (cnt_q != '0);
                LongDoneE = (cnt_q == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use and long-op
// stalls, branch/PC-write flushes and saturating stall/flush counters.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int LONG_LATENCY = 4,
    parameter int CNT_W        = 3,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        RA1D,
    input  logic [3:0]        RA2D,
    input  logic [3:0]        RA1E,
    input  logic [3:0]        RA2E,
    input  logic [3:0]        WA3E,
    input  logic [3:0]        WA3M,
    input  logic [3:0]        WA3W,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              PCSrcW,
    input  logic              PCWrPendingF,
    input  logic              BranchTakenE,
    input  logic              LongOpE,
    input  logic              PerfClear,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              LongDoneE,
    output logic [PERF_W-1:0] StallCount,
    output logic [PERF_W-1:0] FlushCount
);

    logic              ld_stall;
    logic              long_stall;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    hazard_longop_seq #(
        .LONG_LATENCY (LONG_LATENCY),
        .CNT_W        (CNT_W)
    ) u_longop (
        .clk       (clk),
        .reset     (reset),
        .LongOpE   (LongOpE),
        .LongStall (long_stall),
        .LongDoneE (LongDoneE)
    );

    assign ForwardAE = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA1E);
    assign ForwardBE = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA2E);

    assign ld_stall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));

    assign StallE = long_stall;
    assign StallD = ld_stall || long_stall;
    assign StallF = ld_stall || long_stall || PCWrPendingF;

    // A held Execute stage must not be bubbled; M takes the bubbles instead.
    assign FlushD = PCWrPendingF || PCSrcW || BranchTakenE;
    assign FlushE = (ld_stall || BranchTakenE) && !long_stall;
    assign FlushM = long_stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (PerfClear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (StallD && !(&stall_cnt_q))
                stall_cnt_d = stall_cnt_q + PERF_W'(1);
            if (FlushE && !(&flush_cnt_q))
                flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and random checks of hazard_unit against a cycle-by-cycle
// behavioural model (long op tracked by age since entering Execute).
module tb_hazard_unit;

    localparam int L      = 4;
    localparam int PW     = 4;
    localparam int CMAX   = (1 << PW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF;
    logic BranchTakenE, LongOpE, PerfClear;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, LongDoneE;
    logic [PW-1:0] StallCount, FlushCount;

    int errors = 0;
    int checks = 0;
    int age = -1;
    int sc  = 0;
    int fc  = 0;

    always #5 clk = ~clk;

    hazard_unit #(.LONG_LATENCY(L), .CNT_W(3), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE),
        .LongOpE(LongOpE), .PerfClear(PerfClear),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .LongDoneE(LongDoneE), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int fwd(input logic [3:0] ra);
        if (ra == 4'd15) return 0;
        if (RegWriteM && WA3M == ra) return 2;
        if (RegWriteW && WA3W == ra) return 1;
        return 0;
    endfunction

    // Evaluate the model mid-cycle, compare every output, then advance the model.
    task automatic step();
        int cur;
        bit lstall, done, ld, e_stalld, e_flushe;
        @(negedge clk);
        if (!reset) begin
            age = -1; sc = 0; fc = 0;
        end
        cur      = (age < 0 && LongOpE) ? 0 : age;
        lstall   = (cur >= 0) && (cur < L - 1);
        done     = (cur == L - 1);
        ld       = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
        e_stalld = ld || lstall;
        e_flushe = (ld || BranchTakenE) && !lstall;
        chk("ForwardAE",  int'(ForwardAE),  fwd(RA1E));
        chk("ForwardBE",  int'(ForwardBE),  fwd(RA2E));
        chk("StallF",     int'(StallF),     int'(e_stalld || PCWrPendingF));
        chk("StallD",     int'(StallD),     int'(e_stalld));
        chk("StallE",     int'(StallE),     int'(lstall));
        chk("FlushD",     int'(FlushD),     int'(PCWrPendingF || PCSrcW || BranchTakenE));
        chk("FlushE",     int'(FlushE),     int'(e_flushe));
        chk("FlushM",     int'(FlushM),     int'(lstall));
        chk("LongDoneE",  int'(LongDoneE),  int'(done));
        chk("StallCount", int'(StallCount), sc);
        chk("FlushCount", int'(FlushCount), fc);
        if (reset) begin
            if (PerfClear) begin
                sc = 0; fc = 0;
            end else begin
                if (e_stalld) sc = (sc < CMAX) ? sc + 1 : CMAX;
                if (e_flushe) fc = (fc < CMAX) ? fc + 1 : CMAX;
            end
            age = (cur < 0 || cur == L - 1) ? -1 : cur + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
        WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
        RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; PCSrcW = 0;
        PCWrPendingF = 0; BranchTakenE = 0; LongOpE = 0; PerfClear = 0;
    endtask

    function automatic logic [3:0] raddr();
        return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        clr();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        // Forwarding priority and the PC exclusion
        RegWriteM = 1; WA3M = 4'd3; RegWriteW = 1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
        step();
        RegWriteM = 0;
        step();
        RegWriteM = 1; RA1E = 4'd15;
        step();
        clr();

        // Single load-use stall
        MemtoRegE = 1; WA3E = 4'd5; RA2D = 4'd5;
        step();
        clr();
        step();

        // Long op, then long op coinciding with load-use
        LongOpE = 1;
        repeat (L) step();
        LongOpE = 0;
        step();
        LongOpE = 1; MemtoRegE = 1; WA3E = 4'd7; RA1D = 4'd7;
        repeat (L) step();
        LongOpE = 0;
        step();
        clr();

        // Back-to-back long ops
        LongOpE = 1;
        repeat (2 * L + 1) step();
        clr();
        step();

        BranchTakenE = 1;
        step();
        clr();
        PCWrPendingF = 1;
        step();
        clr();
        PCSrcW = 1;
        step();
        clr();

        // Reset in the second cycle of a long op
        LongOpE = 1;
        step();
        LongOpE = 0; reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (L) step();

        // Counter saturation, then clear against a simultaneous increment
        MemtoRegE = 1; WA3E = 4'd2; RA1D = 4'd2;
        repeat (CMAX + 3) step();
        PerfClear = 1;
        step();
        PerfClear = 0;
        step();
        clr();
        step();

        repeat (400) begin
            RA1D = raddr(); RA2D = raddr(); RA1E = raddr(); RA2E = raddr();
            WA3E = raddr(); WA3M = raddr(); WA3W = raddr();
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemtoRegE    = ($urandom_range(0, 3) == 0);
            PCSrcW       = ($urandom_range(0, 7) == 0);
            PCWrPendingF = ($urandom_range(0, 5) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            LongOpE      = ($urandom_range(0, 4) == 0);
            PerfClear    = ($urandom_range(0, 30) == 0);
            reset        = ($urandom_range(0, 60) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
